decrypt: RTL and testbench
==========================

DECRYPT -- requirements
Module: decrypt

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: reset is asynchronous and active-low, named resetn; clock is named clock.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: resetn  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  in IDLE, begins a new block; ignored in all other states.
REQ-005 Port: in_valid  input  1  the in byte is valid this cycle.
REQ-006 Port: in  input  8  ciphertext byte, sent in FIPS-197 order (byte 0 first = message[127:120]).
REQ-007 Port: in_ready  output  1  high only in LOAD.
REQ-008 Port: key_round  output  4  round-key number requested (0..10).
REQ-009 Port: key_idx  output  4  byte index requested within that round key (0..15).
REQ-010 Port: key  input  8  round-key byte for (key_round, key_idx), returned combinationally in the same cycle by an external key store.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: done  output  1  one-cycle pulse; message holds the plaintext in that cycle.
REQ-013 Port: message  output  128  128-bit working state; byte i is message[127-8i -: 8], row i%4, column i/4.

Function
REQ-014 SHALL implement the AES-128 inverse cipher on one 128-bit register.
- Load: state = C ^ K10.
- Rounds r = 9..1: InvShiftRows, InvSubBytes, AddRoundKey(Kr), InvMixColumns.
- Final round: InvShiftRows, InvSubBytes, AddRoundKey(K0).
REQ-015 FSM states: IDLE, LOAD, INV_SHIFT, INV_SUB, ADD_RK, INV_MIX, DONE.
REQ-016 IDLE->LOAD on start. LOAD->INV_SHIFT after the 16th accepted byte; the round counter is set to 9 on that transition.
REQ-017 LOAD: key_round=10, key_idx=byte count. Each byte is accepted only when in_valid=1 and is written as in^key into byte[count]. Cycles with in_valid=0 stall LOAD and leave count and message unchanged.
REQ-018 INV_SHIFT: 1 cycle. Row r rotates right by r byte positions across the whole register.
REQ-019 INV_SUB: 16 cycles. Cycle j replaces byte j with InvSbox(byte j).
REQ-020 ADD_RK: 16 cycles. Cycle j drives key_round=round and key_idx=j, and sets byte j = byte j ^ key.
REQ-021 ADD_RK exit: if round>0, go to INV_MIX; if round=0, go to DONE.
REQ-022 INV_MIX: 4 cycles. Cycle c replaces column c with InvMixColumns over GF(2^8) (poly 0x11B, coefficients 0E/0B/0D/09). It then goes to INV_SHIFT and decrements round.
REQ-023 DONE: 1 cycle with done=1, then return to IDLE.
REQ-024 Latency: done SHALL be high in the cycle beginning exactly 366 rising edges after the edge that accepts the 16th byte (9x37 + 33).
REQ-025 After DONE, message SHALL hold the plaintext until the first byte of the next block is accepted.
REQ-026 Outside LOAD and ADD_RK, key_round and key_idx SHALL be 0.
REQ-027 A start asserted while busy=1 SHALL be ignored and have no later effect.
REQ-028 When start and in_valid are both high in IDLE, the byte SHALL NOT be accepted; the first byte is accepted in LOAD at the earliest.

Reset
REQ-029 While resetn=0, regardless of clock, the block SHALL hold:
- state=IDLE, byte count and column counter=0, round=0;
- message=0, done=0, busy=0, in_ready=0, key_round=0, key_idx=0.
REQ-030 Reset asserted mid-operation SHALL abandon the block. After release, the block SHALL wait in IDLE for a new start.

Structure
REQ-031 A shared package aes_pkg SHALL hold:
- the FSM state encoding;
- NUM_ROUNDS=10 and BLOCK_BYTES=16;
- GF(2^8) functions xtime and gmul, shared with the encrypt path.
REQ-032 The inverse S-box SHALL be a separate combinational sub-module, inv_sbox (8-bit in, 8-bit out, 256-entry table), with one instance in decrypt.
REQ-033 InvShiftRows and InvMixColumns SHALL be implemented inline in decrypt.

Verification
REQ-034 Known answer: key 000102030405060708090a0b0c0d0e0f (bench models the key store), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> message=00112233445566778899aabbccddeeff when done=1, exactly 366 edges after the last byte.
REQ-035 Stalled load: same vector with in_valid low for 3 random cycles between bytes -> identical plaintext; done is delayed only by the stall cycles.
REQ-036 Unit checks:
- inv_sbox: 0x63->0x00, 0x7c->0x01, 0xed->0x53.
- InvMixColumns on column 8e4da1bc -> db135345.
REQ-037 Reset mid-block: resetn low during round 5 INV_SUB -> all outputs 0 and busy=0. A following full vector then decrypts correctly.
REQ-038 start pulsed while busy, and start+in_valid together in IDLE -> no extra block, no byte accepted in IDLE, and the result matches REQ-034.
REQ-039 Back-to-back: two blocks with start issued the cycle after done -> both plaintexts correct; message holds block 1 until block 2's first byte is accepted.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, block geometry
// and GF(2^8) helpers used by both cipher directions.
package aes_pkg;

    localparam int NUM_ROUNDS  = 10;
    localparam int BLOCK_BYTES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INV_SHIFT,
        ST_INV_SUB,
        ST_ADD_RK,
        ST_INV_MIX,
        ST_DONE
    } state_e;

    // Multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a small constant (coefficients up to 0x0F)
    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [3:0] c
    );
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? a  : 8'h00)
             ^ (c[1] ? x2 : 8'h00)
             ^ (c[2] ? x4 : 8'h00)
             ^ (c[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box: purely combinational 256-entry lookup.
// One instance serves the byte-serial InvSubBytes step.
module inv_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [7:0] TBL [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign out_o = TBL[in_i];

endmodule

// File: rtl/decrypt.sv
// Byte-serial AES-128 inverse cipher on a single 128-bit state.
// Round keys are fetched one byte at a time from an external store.
module decrypt
    import aes_pkg::*;
(
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in,
    output logic         in_ready,
    output logic [3:0]   key_round,
    output logic [3:0]   key_idx,
    input  logic [7:0]   key,
    output logic         busy,
    output logic         done,
    output logic [127:0] message
);

    // Byte i of the block lives at msg_q[15-i], i.e. msg_q[~i]
    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       round_q, round_d;
    logic [15:0][7:0] msg_q, msg_d;

    logic [15:0][7:0] shifted;
    logic [3:0][7:0]  col_in;
    logic [3:0][7:0]  col_out;
    logic [7:0]       sbox_in;
    logic [7:0]       sbox_out;

    inv_sbox u_inv_sbox (
        .in_i  (sbox_in),
        .out_o (sbox_out)
    );

    assign sbox_in = msg_q[~cnt_q];
    assign message = msg_q;

    // InvShiftRows: row r rotates right by r columns
    assign shifted[15] = msg_q[15];
    assign shifted[14] = msg_q[2];
    assign shifted[13] = msg_q[5];
    assign shifted[12] = msg_q[8];
    assign shifted[11] = msg_q[11];
    assign shifted[10] = msg_q[14];
    assign shifted[9]  = msg_q[1];
    assign shifted[8]  = msg_q[4];
    assign shifted[7]  = msg_q[7];
    assign shifted[6]  = msg_q[10];
    assign shifted[5]  = msg_q[13];
    assign shifted[4]  = msg_q[0];
    assign shifted[3]  = msg_q[3];
    assign shifted[2]  = msg_q[6];
    assign shifted[1]  = msg_q[9];
    assign shifted[0]  = msg_q[12];

    // Select the column being mixed this cycle
    assign col_in[0] = msg_q[~{col_q, 2'd0}];
    assign col_in[1] = msg_q[~{col_q, 2'd1}];
    assign col_in[2] = msg_q[~{col_q, 2'd2}];
    assign col_in[3] = msg_q[~{col_q, 2'd3}];

    // InvMixColumns on one column
    always_comb begin
        col_out[0] = gmul(col_in[0], 4'he) ^ gmul(col_in[1], 4'hb)
                   ^ gmul(col_in[2], 4'hd) ^ gmul(col_in[3], 4'h9);
        col_out[1] = gmul(col_in[0], 4'h9) ^ gmul(col_in[1], 4'he)
                   ^ gmul(col_in[2], 4'hb) ^ gmul(col_in[3], 4'hd);
        col_out[2] = gmul(col_in[0], 4'hd) ^ gmul(col_in[1], 4'h9)
                   ^ gmul(col_in[2], 4'he) ^ gmul(col_in[3], 4'hb);
        col_out[3] = gmul(col_in[0], 4'hb) ^ gmul(col_in[1], 4'hd)
                   ^ gmul(col_in[2], 4'h9) ^ gmul(col_in[3], 4'he);
    end

    // Next-state, datapath updates and outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        round_d   = round_q;
        msg_d     = msg_q;
        in_ready  = 1'b0;
        key_round = 4'd0;
        key_idx   = 4'd0;
        busy      = (state_q != ST_IDLE);
        done      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = 4'd0;
                end
            end
            ST_LOAD: begin
                in_ready  = 1'b1;
                key_round = 4'(NUM_ROUNDS);
                key_idx   = cnt_q;
                if (in_valid) begin
                    msg_d[~cnt_q] = in ^ key;
                    cnt_d         = cnt_q + 4'd1;
                    if (cnt_q == 4'(BLOCK_BYTES - 1)) begin
                        state_d = ST_INV_SHIFT;
                        round_d = 4'(NUM_ROUNDS - 1);
                    end
                end
            end
            ST_INV_SHIFT: begin
                msg_d   = shifted;
                cnt_d   = 4'd0;
                state_d = ST_INV_SUB;
            end
            ST_INV_SUB: begin
                msg_d[~cnt_q] = sbox_out;
                cnt_d         = cnt_q + 4'd1;
                if (cnt_q == 4'(BLOCK_BYTES - 1)) begin
                    state_d = ST_ADD_RK;
                end
            end
            ST_ADD_RK: begin
                key_round     = round_q;
                key_idx       = cnt_q;
                msg_d[~cnt_q] = msg_q[~cnt_q] ^ key;
                cnt_d         = cnt_q + 4'd1;
                if (cnt_q == 4'(BLOCK_BYTES - 1)) begin
                    col_d   = 2'd0;
                    state_d = (round_q == 4'd0) ? ST_DONE
                                                : ST_INV_MIX;
                end
            end
            ST_INV_MIX: begin
                msg_d[~{col_q, 2'd0}] = col_out[0];
                msg_d[~{col_q, 2'd1}] = col_out[1];
                msg_d[~{col_q, 2'd2}] = col_out[2];
                msg_d[~{col_q, 2'd3}] = col_out[3];
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = ST_INV_SHIFT;
                    round_d = round_q - 4'd1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and working block registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            col_q   <= 2'd0;
            round_q <= 4'd0;
            msg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            round_q <= round_d;
            msg_q   <= msg_d;
        end
    end

endmodule

// File: tb/tb_decrypt.sv
// Self-checking bench for decrypt: models the key store and
// derives expected plaintext from an independent AES model.
module tb_decrypt;

  localparam logic [127:0] KAT_KEY =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_CT =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT_PT =
    128'h00112233445566778899aabbccddeeff;

  logic         clock;
  logic         resetn;
  logic         start;
  logic         in_valid;
  logic [7:0]   din;
  logic         in_ready;
  logic [3:0]   key_round;
  logic [3:0]   key_idx;
  logic [7:0]   key;
  logic         busy;
  logic         done;
  logic [127:0] message;

  logic [7:0]   sb_in;
  logic [7:0]   sb_out;

  logic [7:0]   rk [0:10][0:15];
  logic [7:0]   sb [256];
  logic [7:0]   isb [256];

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  decrypt dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .in_valid  (in_valid),
    .in        (din),
    .in_ready  (in_ready),
    .key_round (key_round),
    .key_idx   (key_idx),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .message   (message)
  );

  inv_sbox u_sb (
    .in_i  (sb_in),
    .out_o (sb_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // external key store, combinational
  always_comb begin
    key = 8'h00;
    if (key_round <= 4'd10)
      key = rk[key_round][key_idx];
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // polynomial product then reduction by 0x11B
  function automatic logic [7:0] m_gmul(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] m_rotl(input logic [7:0] v,
                                        input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  // S-box from GF inverse plus affine map, then inverted
  task automatic gen_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2)
        ^ m_rotl(inv, 3) ^ m_rotl(inv, 4) ^ 8'h63;
      sb[x] = b;
      isb[b] = 8'(x);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]],
             sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = m_gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      for (int j = 0; j < 16; j++)
        rk[r][j] = w[4*r + j/4][31 - 8*(j%4) -: 8];
  endtask

  function automatic logic [31:0] m_invmix(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] o [4];
    logic [7:0] cf [4];
    cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    for (int k = 0; k < 4; k++) a[k] = col[31 - 8*k -: 8];
    for (int k = 0; k < 4; k++) begin
      o[k] = 8'h00;
      for (int j = 0; j < 4; j++)
        o[k] = o[k] ^ m_gmul(cf[(j - k) & 3], a[j]);
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction

  // inverse cipher on a 4x4 state matrix
  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  col;
    logic [127:0] pt;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = ct[127 - 8*(4*c + r) -: 8] ^ rk[10][4*c + r];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][(c + r) % 4] = s[r][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = isb[t[r][c]] ^ rk[rnd][4*c + r];
      if (rnd > 0)
        for (int c = 0; c < 4; c++) begin
          col = m_invmix({s[0][c], s[1][c], s[2][c], s[3][c]});
          {s[0][c], s[1][c], s[2][c], s[3][c]} = col;
        end
    end
    pt = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        pt[127 - 8*(4*c + r) -: 8] = s[r][c];
    return pt;
  endfunction

  task automatic send_block(input logic [127:0] ct,
                            input int nstall,
                            input bit noise,
                            input bit hchk,
                            input logic [127:0] hold,
                            output int s_cyc,
                            output int acc);
    int st [16];
    foreach (st[i]) st[i] = 0;
    for (int k = 0; k < nstall; k++)
      st[$urandom_range(1, 15)]++;
    @(negedge clock);
    start = 1'b1;
    if (noise) begin
      in_valid = 1'b1;
      din = 8'h5a;
    end
    @(negedge clock);
    start = 1'b0;
    in_valid = 1'b0;
    s_cyc = cyc;
    chk("in_ready_load", in_ready, 1);
    if (hchk) chk("msg_hold", message, hold);
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < st[i]; k++) begin
        in_valid = 1'b0;
        @(negedge clock);
      end
      in_valid = 1'b1;
      din = ct[127 - 8*i -: 8];
      if (noise && i == 7) start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    in_valid = 1'b0;
    acc = cyc;
    chk("in_ready_off", in_ready, 0);
  endtask

  task automatic wait_done(input bit noise,
                           output logic [127:0] pt,
                           output int dcyc);
    dcyc = -1;
    pt = '0;
    for (int k = 0; k < 600; k++) begin
      if (done) begin
        dcyc = cyc;
        pt = message;
        break;
      end
      start = (noise && k == 100);
      @(negedge clock);
    end
    start = 1'b0;
    if (dcyc < 0) chk("done_seen", done, 1);
  endtask

  task automatic run_block(input logic [127:0] ct,
                           input int nstall,
                           input bit noise,
                           input bit hchk,
                           input logic [127:0] hold,
                           output logic [127:0] pt,
                           output int lat,
                           output int tot);
    int s, a, d;
    send_block(ct, nstall, noise, hchk, hold, s, a);
    wait_done(noise, pt, d);
    lat = d - a;
    tot = d - s;
  endtask

  logic [127:0] pt, pt2, ct, exp_pt;
  int lat, tot, ns, s_cyc, acc, bad;

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    din = 8'h00;
    sb_in = 8'h00;
    gen_sbox();
    load_key(KAT_KEY);
    repeat (3) @(negedge clock);
    chk("reset_outs",
        {message, busy, done, in_ready, key_round, key_idx}, 0);
    resetn = 1'b1;

    // inverse S-box unit checks
    sb_in = 8'h63; #1 chk("isb_63", sb_out, 8'h00);
    sb_in = 8'h7c; #1 chk("isb_7c", sb_out, 8'h01);
    sb_in = 8'hed; #1 chk("isb_ed", sb_out, 8'h53);
    bad = 0;
    for (int x = 0; x < 256; x++) begin
      sb_in = 8'(x);
      #1 if (sb_out !== isb[x]) bad++;
    end
    chk("isb_all", bad, 0);
    chk("invmix_col", m_invmix(32'h8e4da1bc), 32'hdb135345);
    chk("ref_kat", ref_dec(KAT_CT), KAT_PT);

    // known answer
    run_block(KAT_CT, 0, 0, 0, 0, pt, lat, tot);
    chk("kat_pt", pt, KAT_PT);
    chk("kat_lat", lat, 366);
    @(negedge clock);
    chk("done_pulse", done, 0);

    // stalled load
    run_block(KAT_CT, 3, 0, 0, 0, pt, lat, tot);
    chk("stall_pt", pt, KAT_PT);
    chk("stall_lat", lat, 366);
    chk("stall_tot", tot, 16 + 3 + 366);

    // start noise while busy and with in_valid in IDLE
    run_block(KAT_CT, 0, 1, 0, 0, pt, lat, tot);
    chk("noise_pt", pt, KAT_PT);
    chk("noise_lat", lat, 366);
    repeat (4) @(negedge clock);
    chk("noise_idle", busy, 0);
    chk("noise_hold", message, KAT_PT);

    // reset during round 5 InvSubBytes
    send_block(KAT_CT, 0, 0, 0, 0, s_cyc, acc);
    while (cyc < acc + 155) @(negedge clock);
    chk("sub_keys_zero", {key_round, key_idx}, 0);
    chk("sub_busy", busy, 1);
    #2 resetn = 1'b0;
    #1 chk("mid_rst_outs",
           {message, busy, done, in_ready, key_round, key_idx}, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    chk("post_rst_idle", busy, 0);
    run_block(KAT_CT, 0, 0, 0, 0, pt, lat, tot);
    chk("post_rst_pt", pt, KAT_PT);

    // back-to-back blocks
    ct = {$urandom, $urandom, $urandom, $urandom};
    run_block(KAT_CT, 0, 0, 0, 0, pt, lat, tot);
    chk("b2b_pt1", pt, KAT_PT);
    run_block(ct, 0, 0, 1, KAT_PT, pt2, lat, tot);
    chk("b2b_pt2", pt2, ref_dec(ct));
    chk("b2b_lat2", lat, 366);

    // random keys and ciphertexts
    for (int n = 0; n < 5; n++) begin
      load_key({$urandom, $urandom, $urandom, $urandom});
      ct = {$urandom, $urandom, $urandom, $urandom};
      ns = $urandom_range(0, 4);
      exp_pt = ref_dec(ct);
      run_block(ct, ns, 0, 0, 0, pt, lat, tot);
      chk("rnd_pt", pt, exp_pt);
      chk("rnd_lat", lat, 366);
      chk("rnd_tot", tot, 16 + ns + 366);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
